timestamp_sender: RTL
=====================

Name: timestamp_sender

Overview:
- Transmit end of the 8-bit timestamp bus: snapshots a 64-bit {seconds, microseconds} timestamp on request and serializes it as pre_stb + 8 bytes (s0,s1,s2,s3,u0,u1,u2,u3).
- Sits in the sclk timing domain beside the RTC; feeds the per-channel timestamp receivers/FIFOs.
- Provides one-deep request buffering, an enforced inter-frame gap and a sticky overrun flag.

Parameters:
- GAP_CYCLES, 2, minimum idle cycles between the last data byte and the next pre_stb; legal range 1..15.

Ports:
- sclk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ts_sec  input  32  current seconds from the RTC.
- ts_usec  input  20  current microseconds from the RTC, 0..999999.
- ts_stb  input  1  single-cycle snapshot request; ts_sec/ts_usec are sampled on the same cycle.
- ovr_clr  input  1  clears the overrun flag.
- pre_stb  output  1  marks the cycle before the first data byte.
- dout  output  8  serialized data byte.
- busy  output  1  high in PRE, SEND and GAP states, or when the pending slot is full.
- overrun  output  1  sticky flag: a request was dropped.

Behaviour:
- Reset (rst=1 at a clock edge): pre_stb=0, dout=0, busy=0, overrun=0. State goes to IDLE; the pending slot is emptied and the byte counter is set to 0. Reset mid-frame truncates the frame immediately, with no further bytes sent.
- FSM states are IDLE, PRE, SEND, GAP.
- IDLE:
  - ts_stb=1 at edge n: the 52-bit snapshot is latched into the shift register and state goes to PRE.
  - pre_stb=1 during cycle n+1. This is the single-cycle latency from request to strobe.
  - With the pending slot full: it is loaded into the shift register instead.
- PRE: lasts 1 cycle, then goes to SEND with count=0.
- SEND: lasts 8 cycles, n+2..n+9. dout carries in order:
  - s0=sec[7:0], s1=sec[15:8], s2=sec[23:16], s3=sec[31:24]
  - u0=usec[7:0], u1=usec[15:8], u2={4'b0,usec[19:16]}, u3=8'h00
  - After count 7 the state goes to GAP.
- GAP: lasts GAP_CYCLES cycles, then goes to IDLE.
  - If the pending slot is full, the next frame's pre_stb comes exactly GAP_CYCLES+1 cycles after u3.
- dout is 8'h00 in every cycle outside SEND. pre_stb is 0 outside PRE.
- Request while PRE, SEND or GAP:
  - Pending slot empty: the snapshot is stored in the pending slot.
  - Pending slot full: the request is dropped and overrun is set. The stored pending value is unchanged, so the oldest request wins.
- The pending slot is consumed when the frame it holds enters PRE.
- ts_stb in the same cycle the pending slot is consumed: the new request fills the freed slot with no overrun.
- The active frame data is held in its own register and is never altered by later requests.
- ovr_clr clears overrun. If ovr_clr and a dropping request occur in the same cycle, the set wins and overrun=1.
- Arithmetic: the byte counter is 3 bits and terminates at 7. The gap counter is 4 bits and loaded with GAP_CYCLES-1. No saturation is needed beyond these.

Test Plan:
- Single request, idle:
  - Stimulus: ts_sec=32'h12345678, ts_usec=20'hABCDE, ts_stb at edge 10.
  - Required: pre_stb=1 in cycle 11; dout sequence 78,56,34,12,DE,BC,0A,00 in cycles 12-19; dout=00 otherwise; busy=1 in cycles 11-21 (GAP_CYCLES=2).
- Back-to-back:
  - Stimulus: second ts_stb (sec=1, usec=2) during cycle 14.
  - Required: second pre_stb in cycle 22; its dout reads 01,00,00,00,02,00,00,00; overrun=0.
- Overrun:
  - Stimulus: three ts_stb during one frame (cycles 13, 15, 17).
  - Required: the second frame carries the cycle-15 snapshot; the cycle-17 request is lost; overrun=1 from cycle 18 until ovr_clr; ovr_clr clears it the cycle after assertion.
- Consume/fill collision:
  - Stimulus: ts_stb in the same cycle the pending frame enters PRE.
  - Required: a third frame follows after the gap; overrun stays 0.
- Reset mid-frame:
  - Stimulus: rst during byte s2.
  - Required: the next cycle has dout=00, pre_stb=0, busy=0; pending is cleared; a new ts_stb produces a clean frame.
- Gap parameter:
  - Stimulus: GAP_CYCLES=1 and GAP_CYCLES=15, with pending requests queued.
  - Required: the next pre_stb appears exactly 2 and 16 cycles after u3 respectively.

Source files
------------

// File: rtl/timestamp_sender_if.sv
// rtl/timestamp_sender_if.sv - timestamp request and 8-bit timestamp bus signal bundle
interface timestamp_sender_if;
   logic [31:0] ts_sec;
   logic [19:0] ts_usec;
   logic        ts_stb;
   logic        ovr_clr;
   logic        pre_stb;
   logic [7:0]  dout;
   logic        busy;
   logic        overrun;

   modport master (
      output ts_sec, ts_usec, ts_stb, ovr_clr,
      input  pre_stb, dout, busy, overrun
   );

   modport slave (
      input  ts_sec, ts_usec, ts_stb, ovr_clr,
      output pre_stb, dout, busy, overrun
   );
endinterface

// File: rtl/timestamp_sender.sv
// rtl/timestamp_sender.sv - snapshots {sec, usec} on request and serializes it as pre_stb + 8 bytes
// One-deep pending slot, enforced inter-frame gap, sticky overrun on dropped requests.
module timestamp_sender #(
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic           sclk,
   input  logic           rst,
   timestamp_sender_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PRE, SEND, GAP} state_t;

   localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

   state_t      state;
   logic [51:0] frame;
   logic [51:0] pend;
   logic        pend_valid;
   logic [2:0]  cnt;
   logic [3:0]  gap_cnt;

   logic [51:0] snap;
   logic        gap_done;
   logic        consume;
   logic        to_slot;
   logic        slot_free;
   logic        drop;

   assign snap      = {bus.ts_usec, bus.ts_sec};
   assign gap_done  = (state == GAP) && (gap_cnt == 4'd0);
   assign consume   = pend_valid && ((state == IDLE) || gap_done);
   // An idle sender with nothing pending launches the request directly instead of queueing it.
   assign to_slot   = bus.ts_stb && !((state == IDLE) && !pend_valid);
   assign slot_free = !pend_valid || consume;
   assign drop      = to_slot && !slot_free;

   assign bus.busy  = (state != IDLE) || pend_valid;

   always_ff @(posedge sclk) begin
      if (rst) begin
         state       <= IDLE;
         frame       <= '0;
         pend        <= '0;
         pend_valid  <= 1'b0;
         cnt         <= 3'd0;
         gap_cnt     <= 4'd0;
         bus.pre_stb <= 1'b0;
         bus.dout    <= 8'h00;
         bus.overrun <= 1'b0;
      end else begin
         bus.pre_stb <= 1'b0;
         bus.dout    <= 8'h00;

         case (state)
            IDLE: begin
               if (pend_valid) begin
                  frame       <= pend;
                  state       <= PRE;
                  bus.pre_stb <= 1'b1;
               end else if (bus.ts_stb) begin
                  frame       <= snap;
                  state       <= PRE;
                  bus.pre_stb <= 1'b1;
               end
            end
            PRE: begin
               bus.dout <= frame[7:0];
               frame    <= frame >> 8;
               cnt      <= 3'd0;
               state    <= SEND;
            end
            SEND: begin
               if (cnt == 3'd7) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= GAP;
               end else begin
                  bus.dout <= frame[7:0];
                  frame    <= frame >> 8;
                  cnt      <= cnt + 3'd1;
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) begin
                  // A queued frame starts straight from the gap so back-to-back spacing is exact.
                  if (pend_valid) begin
                     frame       <= pend;
                     state       <= PRE;
                     bus.pre_stb <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase

         if (to_slot && slot_free) begin
            pend       <= snap;
            pend_valid <= 1'b1;
         end else if (consume) begin
            pend_valid <= 1'b0;
         end

         if (bus.ovr_clr) bus.overrun <= 1'b0;
         if (drop)        bus.overrun <= 1'b1;
      end
   end
endmodule
